ex_mem_stage: RTL

Execute stage plus EX/MEM pipeline register of the 5-stage RISC-V core. Consumes the ID/EX register outputs, applies MEM/WB operand forwarding, decodes ALU control from ALU op and instruction funct fields, executes the ALU op, and resolves conditional branches. Results and MEM/WB control bits are registered into the EX/MEM register for the memory stage.

---
 rtl/ex_mem_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// Execute stage of the 5-stage core: operand forwarding, ALU decode/execute, branch resolve,
// followed by the EX/MEM pipeline register (one cycle to the memory stage, no stall).
module ex_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] read_data_1_E,
  input  logic [XLEN-1:0] read_data_2_E,
  input  logic [XLEN-1:0] ImmE,
  input  logic [1:0]      ALUOPE,
  input  logic            RegWriteE,
  input  logic            MemtoRegE,
  input  logic            BranchE,
  input  logic            MemReadE,
  input  logic            MemWriteE,
  input  logic            ALUSrcE,
  input  logic [4:0]      Rs1,
  input  logic [4:0]      Rs2,
  input  logic [4:0]      Rd,
  input  logic [31:0]     Inst_E,
  input  logic            RegWriteM,
  input  logic [4:0]      RdM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic            pc_src_E,
  output logic [XLEN-1:0] branch_target_E,
  output logic [XLEN-1:0] ALUResultM_o,
  output logic [XLEN-1:0] WriteDataM,
  output logic [4:0]      RdM_o,
  output logic            RegWriteM_o,
  output logic            MemtoRegM_o,
  output logic            MemReadM_o,
  output logic            MemWriteM_o,
  output logic [XLEN-1:0] PCM
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_ctrl_t;

  logic [2:0]      funct3;
  logic            funct7b5;
  logic            is_rtype;
  logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_result;
  logic [4:0]      shamt;
  logic            branch_cond;
  alu_ctrl_t       alu_ctrl;
  logic            unused_inst_bits;

  assign funct3   = Inst_E[14:12];
  assign funct7b5 = Inst_E[30];
  assign is_rtype = (Inst_E[6:0] == 7'b0110011);
  assign unused_inst_bits = ^{Inst_E[31], Inst_E[29:15], Inst_E[11:7]};

  // MEM-stage result is younger than WB, so it wins on a double match; x0 never forwards.
  always_comb begin
    fwd_a = read_data_1_E;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs1)
      fwd_a = ALUResultM;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs1)
      fwd_a = ResultW;
  end

  always_comb begin
    fwd_b = read_data_2_E;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs2)
      fwd_b = ALUResultM;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs2)
      fwd_b = ResultW;
  end

  assign src_a = fwd_a;
  assign src_b = ALUSrcE ? ImmE : fwd_b;
  assign shamt = src_b[4:0];

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (ALUOPE)
      2'b01: alu_ctrl = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  alu_ctrl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_SLL:  alu_result = src_a << shamt;
      ALU_SLT:  alu_result = ($signed(src_a) < $signed(src_b)) ? XLEN'(1) : '0;
      ALU_SLTU: alu_result = (src_a < src_b) ? XLEN'(1) : '0;
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SRL:  alu_result = src_a >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(src_a) >>> shamt);
      ALU_OR:   alu_result = src_a | src_b;
      ALU_AND:  alu_result = src_a & src_b;
      default:  alu_result = '0;
    endcase
  end

  // Branches always compare the two register operands, never the immediate.
  always_comb begin
    branch_cond = 1'b0;
    case (funct3)
      3'b000:  branch_cond = (fwd_a == fwd_b);
      3'b001:  branch_cond = (fwd_a != fwd_b);
      3'b100:  branch_cond = ($signed(fwd_a) <  $signed(fwd_b));
      3'b101:  branch_cond = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110:  branch_cond = (fwd_a <  fwd_b);
      3'b111:  branch_cond = (fwd_a >= fwd_b);
      default: branch_cond = 1'b0;
    endcase
  end

  assign pc_src_E        = BranchE & branch_cond;
  assign branch_target_E = PCE + ImmE;

  always_ff @(posedge clk) begin
    if (reset) begin
      ALUResultM_o <= '0;
      WriteDataM   <= '0;
      RdM_o        <= '0;
      RegWriteM_o  <= 1'b0;
      MemtoRegM_o  <= 1'b0;
      MemReadM_o   <= 1'b0;
      MemWriteM_o  <= 1'b0;
      PCM          <= '0;
    end else begin
      ALUResultM_o <= alu_result;
      WriteDataM   <= fwd_b;
      RdM_o        <= Rd;
      RegWriteM_o  <= RegWriteE;
      MemtoRegM_o  <= MemtoRegE;
      MemReadM_o   <= MemReadE;
      MemWriteM_o  <= MemWriteE;
      PCM          <= PCE;
    end
  end

endmodule
